// File: rtl/demorgan_vector_checker.sv
// Purpose: sweeps all four {A,B} vectors into the De Morgan gate set and checks the four responses.
// Latency: SETTLE_CYCLES+2 cycles per vector; done rises 4*(SETTLE_CYCLES+2) edges after start.
// Backpressure: none; start is ignored while a sweep is in flight.
// Ports: clk/rst_n clock and async active-low reset; start begins a sweep;
//   a_out/b_out registered stimulus; dut_* gate responses; busy/done/pass status;
//   err_count saturating failing-vector count; fail_valid/fail_vec first failing vector.
module demorgan_vector_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a_out,
  output logic             b_out,
  input  logic             dut_nanb,
  input  logic             dut_nor,
  input  logic             dut_nand,
  input  logic             dut_nonb,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [1:0]       fail_vec
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [7:0]       CNT_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_idx;
  logic [7:0]       r_cnt;
  logic             r_a;
  logic             r_b;
  logic [ERR_W-1:0] r_err;
  logic             r_fail_valid;
  logic [1:0]       r_fail_vec;

  logic             w_accept;
  logic             w_busy;
  logic             w_done;
  logic             w_exp_nor;
  logic             w_exp_nand;
  logic             w_mismatch;

  // Golden identities: ~A&~B == ~(A|B), ~A|~B == ~(A&B).
  assign w_exp_nor  = ~(r_a | r_b);
  assign w_exp_nand = ~(r_a & r_b);
  // Case inequality so an X/Z response is reported as a failure instead of masked.
  assign w_mismatch = ({dut_nanb, dut_nor, dut_nand, dut_nonb} !==
                       {w_exp_nor, w_exp_nor, w_exp_nand, w_exp_nand});

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_DRIVE;
      S_DRIVE:  w_next = S_SETTLE;
      S_SETTLE: if (r_cnt == CNT_LAST) w_next = S_SAMPLE;
      S_SAMPLE: w_next = (r_idx == 2'd3) ? S_DONE : S_DRIVE;
      S_DONE:   if (start) w_next = S_DRIVE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_busy   = 1'b0;
    w_done   = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE:   w_accept = start;
      S_DRIVE,
      S_SETTLE,
      S_SAMPLE: w_busy = 1'b1;
      S_DONE: begin
        w_done   = 1'b1;
        w_accept = start;
      end
      default: ;
    endcase
  end

  // Sweep datapath: vector index, settle timer, stimulus and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= 2'd0;
      r_cnt        <= 8'd0;
      r_a          <= 1'b0;
      r_b          <= 1'b0;
      r_err        <= '0;
      r_fail_valid <= 1'b0;
      r_fail_vec   <= 2'd0;
    end else if (w_accept) begin
      r_idx        <= 2'd0;
      r_cnt        <= 8'd0;
      r_a          <= 1'b0;
      r_b          <= 1'b0;
      r_err        <= '0;
      r_fail_valid <= 1'b0;
      r_fail_vec   <= 2'd0;
    end else begin
      case (r_state)
        S_DRIVE:  r_cnt <= 8'd0;
        S_SETTLE: r_cnt <= r_cnt + 8'd1;
        S_SAMPLE: begin
          if (w_mismatch) begin
            if (r_err != '1) r_err <= r_err + ERR_ONE;
            if (!r_fail_valid) begin
              r_fail_valid <= 1'b1;
              r_fail_vec   <= {r_a, r_b};
            end
          end
          // Last vector keeps 11 on the stimulus lines through DONE.
          if (r_idx != 2'd3) begin
            r_idx      <= r_idx + 2'd1;
            {r_a, r_b} <= r_idx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign a_out      = r_a;
  assign b_out      = r_b;
  assign busy       = w_busy;
  assign done       = w_done;
  assign pass       = w_done && (r_err == '0);
  assign err_count  = r_err;
  assign fail_valid = r_fail_valid;
  assign fail_vec   = r_fail_vec;

endmodule

// File: tb/tb_demorgan_vector_checker.sv
`timescale 1ns/1ps
// Purpose: randomized sweeps on three checker instances (SETTLE_CYCLES 2, 1, 5) against a vector-level model.
// Latency: expected done edge and per-cycle stimulus vector derived from start edge arithmetic.
// Backpressure: a scoreboard queue per instance, drained by a negedge monitor.
module tb_demorgan_vector_checker;

  localparam int ERR_W = 3;

  typedef struct {
    int         e0;
    int         lat;
    int         errs;
    bit         fv;
    logic [1:0] fvec;
    bit         pas;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [2:0]       start;
  logic [2:0]       a_o, b_o, busy, done, pass, fvld;
  logic [ERR_W-1:0] ec   [3];
  logic [1:0]       fvec [3];
  logic [3:0]       resp [3];
  logic [15:0]      mask [3];
  logic [2:0]       prev_done = 3'b000;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sbq [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Gate models: correct De Morgan responses, with per-vector fault nibbles XORed in.
  // Nibble order {nanb, nor, nand, nonb}; vector v uses mask[4*v +: 4].
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      resp[i] = {~(a_o[i] | b_o[i]), ~(a_o[i] | b_o[i]), ~(a_o[i] & b_o[i]), ~(a_o[i] & b_o[i])}
                ^ mask[i][4*int'({a_o[i], b_o[i]}) +: 4];
    end
  end

  demorgan_vector_checker #(.SETTLE_CYCLES(2), .ERR_W(ERR_W)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .a_out(a_o[0]), .b_out(b_o[0]),
    .dut_nanb(resp[0][3]), .dut_nor(resp[0][2]), .dut_nand(resp[0][1]), .dut_nonb(resp[0][0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(ec[0]),
    .fail_valid(fvld[0]), .fail_vec(fvec[0]));

  demorgan_vector_checker #(.SETTLE_CYCLES(1), .ERR_W(ERR_W)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .a_out(a_o[1]), .b_out(b_o[1]),
    .dut_nanb(resp[1][3]), .dut_nor(resp[1][2]), .dut_nand(resp[1][1]), .dut_nonb(resp[1][0]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(ec[1]),
    .fail_valid(fvld[1]), .fail_vec(fvec[1]));

  demorgan_vector_checker #(.SETTLE_CYCLES(5), .ERR_W(ERR_W)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .a_out(a_o[2]), .b_out(b_o[2]),
    .dut_nanb(resp[2][3]), .dut_nor(resp[2][2]), .dut_nand(resp[2][1]), .dut_nonb(resp[2][0]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(ec[2]),
    .fail_valid(fvld[2]), .fail_vec(fvec[2]));

  function automatic int settle(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 5;
  endfunction

  // Reference: a vector fails iff its fault nibble is nonzero.
  function automatic exp_t model(input int e0, input int s, input logic [15:0] m);
    exp_t x;
    x.e0   = e0;
    x.lat  = 4 * (s + 2);
    x.errs = 0;
    x.fv   = 1'b0;
    x.fvec = 2'd0;
    for (int v = 0; v < 4; v++) begin
      if (m[4*v +: 4] != 4'h0) begin
        if (x.errs < (1 << ERR_W) - 1) x.errs++;
        if (!x.fv) begin
          x.fv   = 1'b1;
          x.fvec = 2'(v);
        end
      end
    end
    x.pas = (x.errs == 0);
    return x;
  endfunction

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s u%0d @cyc %0d: got %0h expected %0h", nm, inst, cyc, act, want);
    end
  endtask

  task automatic check_zero(input int i);
    chk("rst_a_out", i, a_o[i], 0);
    chk("rst_b_out", i, b_o[i], 0);
    chk("rst_busy", i, busy[i], 0);
    chk("rst_done", i, done[i], 0);
    chk("rst_pass", i, pass[i], 0);
    chk("rst_err_count", i, ec[i], 0);
    chk("rst_fail_valid", i, fvld[i], 0);
    chk("rst_fail_vec", i, fvec[i], 0);
  endtask

  // Issue one sweep; optionally re-pulse start pulse_at edges after acceptance.
  task automatic run_sweep(input int i, input logic [15:0] m, input int pulse_at);
    int e0;
    int t;
    @(negedge clk);
    mask[i]  = m;
    start[i] = 1'b1;
    e0 = cyc + 1;
    sbq[i].push_back(model(e0, settle(i), m));
    @(negedge clk);
    start[i] = 1'b0;
    t = 0;
    while (sbq[i].size() != 0 && t < 400) begin
      start[i] = (pulse_at >= 0 && cyc - e0 == pulse_at);
      @(negedge clk);
      t++;
    end
    start[i] = 1'b0;
    if (sbq[i].size() != 0) begin
      chk("sweep_timeout", i, sbq[i].size(), 0);
      sbq[i].delete();
    end
  endtask

  // Monitor: per-cycle sweep checks and end-of-sweep result checks.
  exp_t mon_e;
  int   mon_n;
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (sbq[i].size() > 0 && cyc >= sbq[i][0].e0) begin
        mon_e = sbq[i][0];
        mon_n = cyc - mon_e.e0;
        if (mon_n < mon_e.lat) begin
          chk("busy_in_sweep", i, busy[i], 1);
          chk("done_low_in_sweep", i, done[i], 0);
          chk("pass_low_in_sweep", i, pass[i], 0);
          chk("stim_vector", i, {a_o[i], b_o[i]}, mon_n / (settle(i) + 2));
        end else begin
          chk("done_at_latency", i, done[i], 1);
          chk("busy_low_at_done", i, busy[i], 0);
          chk("hold_vector_11", i, {a_o[i], b_o[i]}, 3);
          chk("err_count", i, ec[i], mon_e.errs);
          chk("fail_valid", i, fvld[i], mon_e.fv);
          if (mon_e.fv) chk("fail_vec", i, fvec[i], mon_e.fvec);
          chk("pass", i, pass[i], mon_e.pas);
          void'(sbq[i].pop_front());
        end
      end else begin
        chk("done_stable_idle", i, done[i], prev_done[i]);
      end
      prev_done[i] <= done[i];
    end
  end

  int          e0;
  int          ri;
  logic [15:0] rm;

  initial begin
    start = 3'b000;
    for (int i = 0; i < 3; i++) mask[i] = 16'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) check_zero(i);
    @(negedge clk);
    #3 rst_n = 1'b1;

    // Reset in the middle of a failing sweep on u0.
    @(negedge clk);
    mask[0]  = 16'hFFFF;
    start[0] = 1'b1;
    e0 = cyc + 1;
    sbq[0].push_back(model(e0, 2, 16'hFFFF));
    @(negedge clk);
    start[0] = 1'b0;
    while (cyc - e0 < 9) @(negedge clk);
    chk("pre_reset_err_count", 0, ec[0], 2);
    #3 rst_n = 1'b0;
    sbq[0].delete();
    #1 check_zero(0);
    @(negedge clk);
    #3 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("no_done_after_reset", 0, done[0], 0);

    // Directed sweeps.
    run_sweep(0, 16'h0000, -1);   // correct gates
    run_sweep(0, 16'h0000, 6);    // start re-pulsed mid-sweep is ignored
    run_sweep(0, 16'h2000, -1);   // nand stuck at 1: vector 11 fails
    run_sweep(0, 16'h0004, -1);   // nor stuck at 0: vector 00 fails
    run_sweep(0, 16'h0004, -1);   // restart from DONE reproduces it
    run_sweep(0, 16'hFFFF, -1);   // all responses inverted
    run_sweep(1, 16'h0000, -1);   // SETTLE_CYCLES=1
    run_sweep(2, 16'h0000, -1);   // SETTLE_CYCLES=5

    // Randomized fault patterns on random instances.
    for (int k = 0; k < 24; k++) begin
      ri = $urandom_range(0, 2);
      rm = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom & $urandom);
      run_sweep(ri, rm, -1);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
